// File: rtl/cpu_defs.sv
// Shared constants and types for the PC sequencing block.
// Default address map, cause codes, FSM state encoding, fetch-address fault helper.
// No logic of its own; imported by npc_calc and pc_ctrl.
package cpu_defs;

   localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;
   localparam logic [31:0] DEF_IMEM_LO    = 32'h0000_3000;
   localparam logic [31:0] DEF_IMEM_HI    = 32'h0000_6FFC;

   // Address error on instruction fetch
   localparam logic [4:0]  EXC_ADEL       = 5'd4;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_HANDLER = 2'd1,
      ST_HALTED  = 2'd2
   } state_t;

   // A fetch address is bad if misaligned or outside the instruction memory window.
   function automatic logic addr_fault(input logic [31:0] a,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
      return (a[1:0] != 2'b00) || (a < lo) || (a > hi);
   endfunction

endpackage

// File: rtl/npc_calc.sv
// Next-PC arithmetic: +4, branch and jump targets, priority pick, fault flag of the pick.
// Purely combinational, zero latency.
// No backpressure; ports: pc/br_imm/j_index/jr_target in, pc_plus4/sel_target/sel_seq/sel_fault out.
module npc_calc
   import cpu_defs::*;
#(
   parameter logic [31:0] IMEM_LO = DEF_IMEM_LO,
   parameter logic [31:0] IMEM_HI = DEF_IMEM_HI
) (
   input  logic [31:0] pc,
   input  logic        br_take,
   input  logic [15:0] br_imm,
   input  logic        jump,
   input  logic [25:0] j_index,
   input  logic        jr,
   input  logic [31:0] jr_target,
   output logic [31:0] pc_plus4,
   output logic [31:0] sel_target,
   output logic        sel_seq,
   output logic        sel_fault
);

   logic [31:0] br_target;
   logic [31:0] j_target;

   // All sums wrap modulo 2^32; a wrapped result is caught by the range check.
   assign pc_plus4  = pc + 32'd4;
   assign br_target = pc_plus4 + {{14{br_imm[15]}}, br_imm, 2'b00};
   assign j_target  = {pc_plus4[31:28], j_index, 2'b00};

   always_comb begin
      sel_target = pc_plus4;
      sel_seq    = 1'b1;
      if (jr) begin
         sel_target = jr_target;
         sel_seq    = 1'b0;
      end else if (jump) begin
         sel_target = j_target;
         sel_seq    = 1'b0;
      end else if (br_take) begin
         sel_target = br_target;
         sel_seq    = 1'b0;
      end
   end

   assign sel_fault = addr_fault(sel_target, IMEM_LO, IMEM_HI);

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter sequencer: owns PC/EPC/cause and the RUN/HANDLER/HALTED FSM.
// Latency 1: the selected next PC appears on pc the cycle after the edge; pc_plus4 is combinational.
// stall holds all state and drops same-cycle jr/jump/branch; halt freezes until reset.
module pc_ctrl
   import cpu_defs::*;
#(
   parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
   parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC,
   parameter logic [31:0] IMEM_LO    = DEF_IMEM_LO,
   parameter logic [31:0] IMEM_HI    = DEF_IMEM_HI
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        br_take,
   input  logic [15:0] br_imm,
   input  logic        jump,
   input  logic [25:0] j_index,
   input  logic        jr,
   input  logic [31:0] jr_target,
   input  logic        exc_req,
   input  logic [4:0]  exc_code,
   input  logic        eret,
   input  logic        halt,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] epc,
   output logic [4:0]  cause,
   output logic        in_handler,
   output logic        halted,
   output logic        redirect
);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] epc_q, epc_d;
   logic [4:0]  cause_q, cause_d;
   logic        redirect_q, redirect_d;

   logic [31:0] sel_target;
   logic        sel_seq;
   logic        sel_fault;
   logic        pc_fault;

   npc_calc #(
      .IMEM_LO (IMEM_LO),
      .IMEM_HI (IMEM_HI)
   ) u_npc (
      .pc         (pc_q),
      .br_take    (br_take),
      .br_imm     (br_imm),
      .jump       (jump),
      .j_index    (j_index),
      .jr         (jr),
      .jr_target  (jr_target),
      .pc_plus4   (pc_plus4),
      .sel_target (sel_target),
      .sel_seq    (sel_seq),
      .sel_fault  (sel_fault)
   );

   // eret restores EPC without a check so the handler can return to whatever
   // was saved; the restored address is then checked as the fetch address on
   // the first RUN cycle, which re-enters the handler if it is bad.
   assign pc_fault = addr_fault(pc_q, IMEM_LO, IMEM_HI);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      epc_d      = epc_q;
      cause_d    = cause_q;
      redirect_d = 1'b0;

      case (state_q)
         ST_RUN: begin
            // eret is meaningless outside the handler and falls through.
            if (exc_req) begin
               epc_d      = pc_q;
               cause_d    = exc_code;
               pc_d       = HANDLER_PC;
               state_d    = ST_HANDLER;
               redirect_d = 1'b1;
            end else if (halt) begin
               state_d = ST_HALTED;
            end else if (stall) begin
               // hold everything
            end else if (pc_fault) begin
               epc_d      = pc_q;
               cause_d    = EXC_ADEL;
               pc_d       = HANDLER_PC;
               state_d    = ST_HANDLER;
               redirect_d = 1'b1;
            end else if (sel_fault) begin
               epc_d      = sel_target;
               cause_d    = EXC_ADEL;
               pc_d       = HANDLER_PC;
               state_d    = ST_HANDLER;
               redirect_d = 1'b1;
            end else begin
               pc_d       = sel_target;
               redirect_d = !sel_seq;
            end
         end

         ST_HANDLER: begin
            // No nested exceptions: exc_req is ignored here.
            if (eret) begin
               pc_d       = epc_q;
               state_d    = ST_RUN;
               redirect_d = 1'b1;
            end else if (halt) begin
               state_d = ST_HALTED;
            end else if (stall) begin
               // hold everything
            end else if (sel_fault) begin
               // A fault inside the handler is unrecoverable; keep pc for debug.
               cause_d = EXC_ADEL;
               state_d = ST_HALTED;
            end else begin
               pc_d       = sel_target;
               redirect_d = !sel_seq;
            end
         end

         ST_HALTED: begin
            // Only reset leaves this state.
         end

         default: begin
            state_d = ST_HALTED;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_RUN;
         pc_q       <= RESET_PC;
         epc_q      <= 32'd0;
         cause_q    <= 5'd0;
         redirect_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         epc_q      <= epc_d;
         cause_q    <= cause_d;
         redirect_q <= redirect_d;
      end
   end

   assign pc         = pc_q;
   assign epc        = epc_q;
   assign cause      = cause_q;
   assign redirect   = redirect_q;
   assign in_handler = (state_q == ST_HANDLER);
   assign halted     = (state_q == ST_HALTED);

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Sequencing controller for the program counter of the single-cycle MIPS core.
- Owns the PC register and selects the next fetch address each cycle from sequential, branch, jump, jump-register, exception and eret sources.
- Applies stall and halt, keeps EPC and cause, and checks every target for alignment and instruction-memory range.
- Feeds the instruction memory address and the link value used by jal.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- HANDLER_PC, 32'h0000_4180, exception handler entry.
- IMEM_LO, 32'h0000_3000, lowest legal fetch address (inclusive).
- IMEM_HI, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold PC this cycle
- br_take  in  1  conditional branch resolved taken
- br_imm  in  16  branch offset (instruction words, signed)
- jump  in  1  j/jal
- j_index  in  26  jump index field
- jr  in  1  jr/jalr
- jr_target  in  32  register target
- exc_req  in  1  external exception request
- exc_code  in  5  cause for exc_req
- eret  in  1  return from handler
- halt  in  1  stop fetching
- pc  out  32  current fetch address
- pc_plus4  out  32  pc+4, combinational link value
- epc  out  32  saved exception PC
- cause  out  5  last exception cause
- in_handler  out  1  FSM in HANDLER
- halted  out  1  FSM in HALTED
- redirect  out  1  one-cycle pulse: the PC just loaded a non-sequential value

Behaviour:
- Decided: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: pc=RESET_PC, epc=0, cause=0, FSM=RUN, redirect=0.
- FSM states: RUN, HANDLER, HALTED. pc updates on the rising clk edge; a new pc is visible the next cycle (latency 1).
- Arithmetic: all modulo 2^32; wrap is silent before the range check.
  - Branch target: pc+4+(sext(br_imm)<<2).
  - Jump target: {pc_plus4[31:28], j_index, 2'b00}.
- Next-PC priority in RUN and HANDLER, highest first:
  1. reset
  2. exc_req
  3. eret
  4. halt
  5. stall
  6. jr
  7. jump
  8. br_take
  9. pc+4
- exc_req in RUN: epc<=pc, cause<=exc_code, pc<=HANDLER_PC, go to HANDLER, redirect=1.
- exc_req in HANDLER is ignored (no nesting); evaluation continues at eret.
- eret in HANDLER: pc<=epc, go to RUN, redirect=1. eret in RUN is ignored.
- halt: go to HALTED; pc frozen. Only reset leaves HALTED; every other input is ignored there.
- stall: pc, epc, cause and state held; redirect=0. A simultaneous jr, jump or br_take is dropped, and the requester must re-present it.
- Fault check: every selected target must have [1:0]==0 and lie in IMEM_LO..IMEM_HI. This covers jr, jump, branch, sequential and eret targets.
  - Fault in RUN: epc<=faulting target, cause<=5'd4, pc<=HANDLER_PC, go to HANDLER, redirect=1.
  - Fault in HANDLER: go to HALTED with cause<=5'd4; pc unchanged.
- redirect=1 for exactly the cycle after any load other than pc+4 or hold.
- reset asserted mid-handler or while halted: full reset values on the next edge.

Decomposition:
- Shared package cpu_defs: RESET_PC, HANDLER_PC, IMEM bounds, cause codes (EXC_ADEL=5'd4), FSM state encoding.
- One natural sub-module: npc_calc. It is purely combinational and produces the branch, jump and +4 targets plus the fault flag.
- pc_ctrl holds the FSM, PC, EPC and cause registers.

Test Plan:
- reset=1 for 2 cycles, then 3 idle cycles -> pc: 0x3000, 0x3004, 0x3008, 0x300C; redirect=0.
- pc=0x3010, br_take=1, br_imm=16'hFFFC -> pc=0x3004 next cycle, redirect=1. Same with br_take and jump=1, j_index=0x0000C10 -> pc=0x3040 (jump wins).
- jr=1, jr_target=0x3002 at pc=0x3020 -> pc=0x4180, epc=0x3002, cause=4, in_handler=1. Then eret=1 -> pc=0x3002, which faults again in RUN and re-enters the handler.
- exc_req=1, exc_code=8 at pc=0x3100 -> pc=0x4180, epc=0x3100. A second exc_req during HANDLER -> ignored. eret -> pc=0x3100, in_handler=0.
- stall=1 for 3 cycles with jump=1 -> pc constant, no redirect. Then halt=1 -> halted=1 and pc frozen for 10 cycles; reset -> pc=0x3000, halted=0.
- Running from pc=0x6FFC with no redirect -> 0x7000 out of range -> HANDLER, epc=0x7000. In the handler, jr to 0x8000 -> HALTED, cause=4.
